// File: rtl/minmax_pkg.sv
// Shared types for the min/max window tracker: compare result and window state encodings.
package minmax_pkg;

    typedef enum logic [1:0] {
        CMP_NONE = 2'd0,
        CMP_EQ   = 2'd1,
        CMP_GT   = 2'd2,
        CMP_LT   = 2'd3
    } cmp_res_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // Collapse the three comparator flags into a single result code.
    function automatic cmp_res_t to_cmp_res(input logic eq, input logic gt, input logic lt);
        if (eq) begin
            return CMP_EQ;
        end else if (gt) begin
            return CMP_GT;
        end else if (lt) begin
            return CMP_LT;
        end
        return CMP_NONE;
    endfunction

endpackage

// File: rtl/minmax_window_tracker_if.sv
// Sample stream and result bus of the min/max window tracker.
// Index outputs exist only when MINMAX_IDX_EN is defined.
interface minmax_window_tracker_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned WIN_LEN = 16
) ();

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             signed_mode;
    logic             clear;
    logic             out_valid;
    logic [WIDTH-1:0] out_min;
    logic [WIDTH-1:0] out_max;
    logic             cmp_eq;
    logic             cmp_gt;
    logic             cmp_lt;
`ifdef MINMAX_IDX_EN
    logic [$clog2(WIN_LEN)-1:0] out_min_idx;
    logic [$clog2(WIN_LEN)-1:0] out_max_idx;
`endif

    modport master (
        output in_valid, in_data, signed_mode, clear,
`ifdef MINMAX_IDX_EN
        input  out_min_idx, out_max_idx,
`endif
        input  out_valid, out_min, out_max, cmp_eq, cmp_gt, cmp_lt
    );

    modport slave (
        input  in_valid, in_data, signed_mode, clear,
`ifdef MINMAX_IDX_EN
        output out_min_idx, out_max_idx,
`endif
        output out_valid, out_min, out_max, cmp_eq, cmp_gt, cmp_lt
    );

endinterface

// File: rtl/cmp_core.sv
// Combinational signed/unsigned magnitude compare via a WIDTH+1 extend-and-subtract.
module cmp_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;
    logic [WIDTH:0] diff;

    // One extra bit holds the full difference range, so its MSB is the true sign.
    assign a_ext = {signed_mode & a[WIDTH-1], a};
    assign b_ext = {signed_mode & b[WIDTH-1], b};
    assign diff  = a_ext - b_ext;

    assign eq = (diff == '0);
    assign lt = diff[WIDTH];
    assign gt = ~eq & ~diff[WIDTH];

endmodule

// File: rtl/minmax_window_tracker.sv
// Running min/max over non-overlapping WIN_LEN-sample windows plus sample-to-sample compare flags.
// Define MINMAX_IDX_EN to also report the in-window position of each extreme.
module minmax_window_tracker
    import minmax_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned WIN_LEN = 16
) (
    input logic                    clk,
    input logic                    rst,
    minmax_window_tracker_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIN_LEN) + 1;
`ifdef MINMAX_IDX_EN
    localparam int unsigned IdxW = $clog2(WIN_LEN);
`endif

    state_t           state_q, state_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             win_mode_q, win_mode_d;
    logic [WIDTH-1:0] run_min_q, run_min_d;
    logic [WIDTH-1:0] run_max_q, run_max_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_valid_q, prev_valid_d;
    cmp_res_t         cmp_q, cmp_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_min_q, out_min_d;
    logic [WIDTH-1:0] out_max_q, out_max_d;
`ifdef MINMAX_IDX_EN
    logic [IdxW-1:0]  run_min_idx_q, run_min_idx_d;
    logic [IdxW-1:0]  run_max_idx_q, run_max_idx_d;
    logic [IdxW-1:0]  out_min_idx_q, out_min_idx_d;
    logic [IdxW-1:0]  out_max_idx_q, out_max_idx_d;
`endif

    logic min_eq, min_gt, min_lt;
    logic max_eq, max_gt, max_lt;
    logic prv_eq, prv_gt, prv_lt;
    logic eff_mode;
    logic new_min, new_max, last_sample;

    // The first sample of a window compares under the mode being latched with it.
    assign eff_mode = (state_q == ST_EMPTY) ? bus.signed_mode : win_mode_q;

    cmp_core #(.WIDTH(WIDTH)) u_cmp_min (
        .a           (bus.in_data),
        .b           (run_min_q),
        .signed_mode (win_mode_q),
        .eq          (min_eq),
        .gt          (min_gt),
        .lt          (min_lt)
    );

    cmp_core #(.WIDTH(WIDTH)) u_cmp_max (
        .a           (bus.in_data),
        .b           (run_max_q),
        .signed_mode (win_mode_q),
        .eq          (max_eq),
        .gt          (max_gt),
        .lt          (max_lt)
    );

    cmp_core #(.WIDTH(WIDTH)) u_cmp_prev (
        .a           (bus.in_data),
        .b           (prev_q),
        .signed_mode (eff_mode),
        .eq          (prv_eq),
        .gt          (prv_gt),
        .lt          (prv_lt)
    );

    assign new_min     = (to_cmp_res(min_eq, min_gt, min_lt) == CMP_LT);
    assign new_max     = (to_cmp_res(max_eq, max_gt, max_lt) == CMP_GT);
    assign last_sample = (count_q == CntW'(WIN_LEN - 1));

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        win_mode_d   = win_mode_q;
        run_min_d    = run_min_q;
        run_max_d    = run_max_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        cmp_d        = cmp_q;
        out_valid_d  = 1'b0;
        out_min_d    = out_min_q;
        out_max_d    = out_max_q;
`ifdef MINMAX_IDX_EN
        run_min_idx_d = run_min_idx_q;
        run_max_idx_d = run_max_idx_q;
        out_min_idx_d = out_min_idx_q;
        out_max_idx_d = out_max_idx_q;
`endif
        if (bus.clear) begin
            state_d      = ST_EMPTY;
            count_d      = '0;
            prev_valid_d = 1'b0;
            cmp_d        = CMP_NONE;
        end else if (bus.in_valid) begin
            prev_d       = bus.in_data;
            prev_valid_d = 1'b1;
            cmp_d        = prev_valid_q ? to_cmp_res(prv_eq, prv_gt, prv_lt) : CMP_NONE;
            if (state_q == ST_EMPTY) begin
                state_d    = ST_ACCUM;
                count_d    = CntW'(1);
                win_mode_d = bus.signed_mode;
                run_min_d  = bus.in_data;
                run_max_d  = bus.in_data;
`ifdef MINMAX_IDX_EN
                run_min_idx_d = '0;
                run_max_idx_d = '0;
`endif
            end else begin
                if (new_min) begin
                    run_min_d = bus.in_data;
`ifdef MINMAX_IDX_EN
                    run_min_idx_d = count_q[IdxW-1:0];
`endif
                end
                if (new_max) begin
                    run_max_d = bus.in_data;
`ifdef MINMAX_IDX_EN
                    run_max_idx_d = count_q[IdxW-1:0];
`endif
                end
                if (last_sample) begin
                    state_d     = ST_EMPTY;
                    count_d     = '0;
                    out_valid_d = 1'b1;
                    out_min_d   = run_min_d;
                    out_max_d   = run_max_d;
`ifdef MINMAX_IDX_EN
                    out_min_idx_d = run_min_idx_d;
                    out_max_idx_d = run_max_idx_d;
`endif
                end else begin
                    count_d = count_q + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            count_q      <= '0;
            win_mode_q   <= 1'b0;
            run_min_q    <= '0;
            run_max_q    <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            cmp_q        <= CMP_NONE;
            out_valid_q  <= 1'b0;
            out_min_q    <= '0;
            out_max_q    <= '0;
`ifdef MINMAX_IDX_EN
            run_min_idx_q <= '0;
            run_max_idx_q <= '0;
            out_min_idx_q <= '0;
            out_max_idx_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            win_mode_q   <= win_mode_d;
            run_min_q    <= run_min_d;
            run_max_q    <= run_max_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            cmp_q        <= cmp_d;
            out_valid_q  <= out_valid_d;
            out_min_q    <= out_min_d;
            out_max_q    <= out_max_d;
`ifdef MINMAX_IDX_EN
            run_min_idx_q <= run_min_idx_d;
            run_max_idx_q <= run_max_idx_d;
            out_min_idx_q <= out_min_idx_d;
            out_max_idx_q <= out_max_idx_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_min   = out_min_q;
    assign bus.out_max   = out_max_q;
    assign bus.cmp_eq    = (cmp_q == CMP_EQ);
    assign bus.cmp_gt    = (cmp_q == CMP_GT);
    assign bus.cmp_lt    = (cmp_q == CMP_LT);
`ifdef MINMAX_IDX_EN
    assign bus.out_min_idx = out_min_idx_q;
    assign bus.out_max_idx = out_max_idx_q;
`endif

endmodule
